button_counter: RTL and testbench
=================================

Name: button_counter

Overview:
- Upstream stage of the 7-segment display driver.
- Takes three raw board pushbuttons (up, down, clear) and synchronizes and debounces each one.
- Converts each press into a single-cycle event and maintains a bounded count.
- Presents the count as a 27-bit binary `number` that the display stage splits into decimal digits.

Parameters:
- WIDTH, 27: width of `number`. Matches the display input.
- MAX_COUNT, 100: upper bound of the count. Legal range 1..99_999_999.
- DEBOUNCE_CYCLES, 1_000_000: number of cycles the synchronized input must stay stable before it is accepted. This is 10 ms at 100 MHz. Minimum 2.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset. 0 = reset asserted.
- btn_up, input, 1: raw asynchronous button. Increment on press.
- btn_down, input, 1: raw asynchronous button. Decrement on press.
- btn_clear, input, 1: raw asynchronous button. Return to 0 on press.
- number, output, WIDTH: current count, registered. Feeds the display stage.
- at_max, output, 1: registered; 1 when number == MAX_COUNT.
- at_min, output, 1: registered; 1 when number == 0.
- changed, output, 1: one-cycle pulse in the cycle `number` takes a new value.

Behaviour:
- Reset (reset = 0, asynchronous): number = 0, at_min = 1, at_max = 0, changed = 0. All synchronizer, debounce and edge registers are cleared to 0 (button released).
- Release of reset is synchronous to clk. The first count update is possible no earlier than DEBOUNCE_CYCLES+3 cycles after release.
- Per-button path:
  - A 2-flop synchronizer produces s2.
  - The debounce counter `cnt` holds 0 while s2 == stable.
  - While s2 != stable, `cnt` increments each cycle.
  - When s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2 and cnt <= 0.
  - A bounce, where s2 returns to equal stable before the limit, resets cnt to 0 and leaves `stable` unchanged.
  - press pulse = stable & ~stable_d, registered, so it lasts exactly one cycle per accepted press.
  - Release and holding generate no pulses.
- Latency: a raw edge sampled at clk edge k produces:
  - stable change at k+1+DEBOUNCE_CYCLES
  - press pulse at k+2+DEBOUNCE_CYCLES
  - number update at k+3+DEBOUNCE_CYCLES
- Count update, evaluated in priority order each cycle:
  1. clear pulse: number <= 0. Up/down pulses in the same cycle are ignored.
  2. up and down pulses together: no change, changed = 0.
  3. up pulse: if number < MAX_COUNT then number+1; at MAX_COUNT, hold (saturate).
  4. down pulse: if number > 0 then number-1; at 0, hold.
- `changed` = 1 only when the new value differs from the old. Clear at 0, up at max and down at 0 give changed = 0.
- at_max and at_min are computed from the next value, so they are coherent with `number` in the same cycle.
- Arithmetic is unsigned, WIDTH bits. `number` never exceeds MAX_COUNT, so the display never needs its modulo path.
- Reset mid-debounce: all progress is lost, and a press still held after reset needs a full new debounce interval.

Optional Feature:
- Macro BUTTON_COUNTER_WRAP_EN.
- Defined: up at MAX_COUNT gives 0; down at 0 gives MAX_COUNT. changed = 1 in both cases. at_max and at_min still decode the value.
- Undefined: saturating behaviour as specified above.

Decomposition:
- Shared package display_pkg holds:
  - NUM_WIDTH = 27
  - DISPLAY_MAX = 99_999_999
  - CLK_HZ = 100_000_000
  - DEBOUNCE_MS = 10
- The display stage and this block both import NUM_WIDTH.
- One sub-module, button_debounce: synchronizer, debounce counter, stable register and press pulse. Parameter DEBOUNCE_CYCLES. Instantiated three times.
- The count logic stays in button_counter.

Test Plan:
All tests use DEBOUNCE_CYCLES = 4 and MAX_COUNT = 100.
1. Reset and clean press: hold reset = 0, then release it. number = 0, at_min = 1. Raise btn_up at edge k and hold it 20 cycles → number = 1 at edge k+7, changed pulses once, and the hold produces no further increments.
2. Bounce: toggle btn_up 1,0,1,0 every 2 cycles, then hold 0 → number unchanged, changed never asserted. Then a clean 10-cycle press → number increments by exactly 1.
3. Saturation: from 99, apply 3 clean up presses → 100, 100, 100; at_max = 1; changed pulses only once. From 0, a down press → 0, changed = 0.
4. Wrap: with BUTTON_COUNTER_WRAP_EN defined, an up press at 100 → 0 and a down press at 0 → 100, changed = 1 in both cases.
5. Simultaneous events: up and down pressed on the same edge at number = 50 → stays 50. Clear, up and down pressed on the same edge at 50 → 0.
6. Reset mid-debounce: press btn_down at number = 7, pulse reset low at debounce count 2 → number = 0 and no decrement occurs. Keeping the button held after reset → number stays 0 (saturated), changed = 0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants for the pushbutton counter and the 7-segment display stage,
// plus the count-operation type and its priority decode.
package display_pkg;

  localparam int NUM_WIDTH        = 27;
  localparam int DISPLAY_MAX      = 99_999_999;
  localparam int CLK_HZ           = 100_000_000;
  localparam int DEBOUNCE_MS      = 10;
  localparam int DEBOUNCE_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

  typedef enum logic [1:0] {
    CNT_HOLD  = 2'd0,
    CNT_CLEAR = 2'd1,
    CNT_INC   = 2'd2,
    CNT_DEC   = 2'd3
  } count_op_e;

  // Clear dominates; opposing up/down presses cancel each other.
  function automatic count_op_e count_op_decode(input logic clear, input logic up,
                                                input logic down);
    count_op_e op;
    if (clear) begin
      op = CNT_CLEAR;
    end else if (up && down) begin
      op = CNT_HOLD;
    end else if (up) begin
      op = CNT_INC;
    end else if (down) begin
      op = CNT_DEC;
    end else begin
      op = CNT_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/button_counter_if.sv
// Board-side bundle of the button counter: raw buttons in, count and flags out.
interface button_counter_if import display_pkg::*; #(
  parameter int WIDTH = NUM_WIDTH
);

  logic             btn_up;
  logic             btn_down;
  logic             btn_clear;
  logic [WIDTH-1:0] number;
  logic             at_max;
  logic             at_min;
  logic             changed;

  modport master (
    output btn_up, btn_down, btn_clear,
    input  number, at_max, at_min, changed
  );

  modport slave (
    input  btn_up, btn_down, btn_clear,
    output number, at_max, at_min, changed
  );

endinterface

// File: rtl/button_debounce.sv
// One pushbutton path: 2-flop synchronizer, stability counter and a
// single-cycle press pulse on each accepted 0->1 transition.
module button_debounce import display_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int                CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_r;
  logic             s2_r;
  logic             stable_r;
  logic             stable_d_r;
  logic             press_r;
  logic [CNT_W-1:0] cnt_r;

  // Two-stage synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= btn;
      s2_r <= s1_r;
    end
  end

  // Accept a new level only after it has differed from stable for the full window;
  // any return to the stable level restarts the window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r    <= '0;
      stable_r <= 1'b0;
    end else if (s2_r != stable_r) begin
      if (cnt_r == LIMIT) begin
        stable_r <= s2_r;
        cnt_r    <= '0;
      end else begin
        cnt_r    <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= '0;
    end
  end

  // Rising-edge detect on the debounced level, registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_d_r <= 1'b0;
      press_r    <= 1'b0;
    end else begin
      stable_d_r <= stable_r;
      press_r    <= stable_r & ~stable_d_r;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/button_counter.sv
// Debounced up/down/clear counter feeding the 7-segment display stage.
// Define BUTTON_COUNTER_WRAP_EN to wrap at the ends instead of saturating.
module button_counter import display_pkg::*; #(
  parameter int WIDTH           = NUM_WIDTH,
  parameter int MAX_COUNT       = 100,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  button_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic             up_press_s;
  logic             down_press_s;
  logic             clear_press_s;
  count_op_e        op_s;
  logic [WIDTH-1:0] next_num_s;
  logic [WIDTH-1:0] number_r;
  logic             at_max_r;
  logic             at_min_r;
  logic             changed_r;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.btn_up),
    .press (up_press_s)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.btn_down),
    .press (down_press_s)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.btn_clear),
    .press (clear_press_s)
  );

  assign op_s = count_op_decode(clear_press_s, up_press_s, down_press_s);

  // Next count value; the ends either hold or wrap depending on the build.
  always_comb begin
    next_num_s = number_r;
    case (op_s)
      CNT_CLEAR: next_num_s = '0;
      CNT_INC: begin
        if (number_r < MAX_VAL) begin
          next_num_s = number_r + ONE;
        end else begin
`ifdef BUTTON_COUNTER_WRAP_EN
          next_num_s = '0;
`else
          next_num_s = number_r;
`endif
        end
      end
      CNT_DEC: begin
        if (number_r != '0) begin
          next_num_s = number_r - ONE;
        end else begin
`ifdef BUTTON_COUNTER_WRAP_EN
          next_num_s = MAX_VAL;
`else
          next_num_s = number_r;
`endif
        end
      end
      default: next_num_s = number_r;
    endcase
  end

  // Flags decode the next value so they line up with number in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      number_r  <= '0;
      at_max_r  <= 1'b0;
      at_min_r  <= 1'b1;
      changed_r <= 1'b0;
    end else begin
      number_r  <= next_num_s;
      at_max_r  <= (next_num_s == MAX_VAL);
      at_min_r  <= (next_num_s == '0);
      changed_r <= (next_num_s != number_r);
    end
  end

  assign bus.number  = number_r;
  assign bus.at_max  = at_max_r;
  assign bus.at_min  = at_min_r;
  assign bus.changed = changed_r;

endmodule

// File: tb/tb_button_counter.sv
// Bench for button_counter with DEBOUNCE_CYCLES=4, MAX_COUNT=100; expectations
// follow BUTTON_COUNTER_WRAP_EN when it is defined.
module tb_button_counter;
  import display_pkg::*;

  localparam int D    = 4;
  localparam int MAXC = 100;
`ifdef BUTTON_COUNTER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct {
    int num;
    bit amax;
    bit amin;
    bit chg;
  } exp_t;

  typedef struct {
    string name;
    bit    up;
    bit    dn;
    bit    clr;
    int    hold;
    int    num;
    bit    amax;
    bit    amin;
    bit    chg;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   model = 0;
  int   last_num = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  button_counter_if #(.WIDTH(NUM_WIDTH)) bus ();

  button_counter #(
    .WIDTH           (NUM_WIDTH),
    .MAX_COUNT       (MAXC),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference count: clear first, up+down cancel, ends saturate or wrap.
  function automatic exp_t predict(input bit up, input bit dn, input bit clr);
    exp_t e;
    int   nxt;
    nxt = model;
    if (clr) nxt = 0;
    else if (up && dn) nxt = model;
    else if (up) nxt = (model < MAXC) ? model + 1 : (WRAP ? 0 : model);
    else if (dn) nxt = (model > 0) ? model - 1 : (WRAP ? MAXC : model);
    e.num  = nxt;
    e.amax = (nxt == MAXC);
    e.amin = (nxt == 0);
    e.chg  = (nxt != model);
    model  = nxt;
    return e;
  endfunction

  // Press buttons at t0; result due exactly D+3 edges after the sampling edge.
  task automatic apply(input string name, input bit up, input bit dn, input bit clr,
                       input int hold, input exp_t e);
    int   pulses;
    exp_t x;
    pulses = 0;
    sb_q.push_back(e);
    bus.btn_up    = up;
    bus.btn_down  = dn;
    bus.btn_clear = clr;
    for (int t = 1; t <= hold + 12; t++) begin
      if (t == hold + 1) begin
        bus.btn_up    = 1'b0;
        bus.btn_down  = 1'b0;
        bus.btn_clear = 1'b0;
      end
      tick(1);
      if (bus.changed === 1'b1) pulses++;
      if (t == D + 3) check({name, "_early"}, bus.number, last_num);
      if (t == D + 4) begin
        x = sb_q.pop_front();
        check({name, "_num"}, bus.number, x.num);
        check({name, "_max"}, bus.at_max, x.amax);
        check({name, "_min"}, bus.at_min, x.amin);
        check({name, "_chg"}, bus.changed, x.chg);
      end
    end
    check({name, "_pulses"}, pulses, e.chg ? 1 : 0);
    last_num = e.num;
  endtask

  task automatic ev(input string name, input bit up, input bit dn, input bit clr);
    exp_t e;
    e = predict(up, dn, clr);
    apply(name, up, dn, clr, 10, e);
  endtask

  initial begin
    vec_t vecs[6];
    exp_t e;
    int   pulses;

    vecs[0] = '{"clean_up_hold20", 1'b1, 1'b0, 1'b0, 20, 1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{"up2",             1'b1, 1'b0, 1'b0, 10, 2, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{"down",            1'b0, 1'b1, 1'b0, 10, 1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{"up_down_cancel",  1'b1, 1'b1, 1'b0, 10, 1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{"clear",           1'b0, 1'b0, 1'b1, 10, 0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{"clear_at_0",      1'b0, 1'b0, 1'b1, 10, 0, 1'b0, 1'b1, 1'b0};

    reset         = 1'b0;
    bus.btn_up    = 1'b0;
    bus.btn_down  = 1'b0;
    bus.btn_clear = 1'b0;
    tick(3);
    check("rst_num", bus.number, 0);
    check("rst_min", bus.at_min, 1);
    check("rst_max", bus.at_max, 0);
    check("rst_chg", bus.changed, 0);
    reset = 1'b1;
    tick(2);
    check("post_rst_num", bus.number, 0);
    check("post_rst_min", bus.at_min, 1);

    foreach (vecs[i]) begin
      e.num  = vecs[i].num;
      e.amax = vecs[i].amax;
      e.amin = vecs[i].amin;
      e.chg  = vecs[i].chg;
      apply(vecs[i].name, vecs[i].up, vecs[i].dn, vecs[i].clr, vecs[i].hold, e);
      model = vecs[i].num;
    end
    ev("up_after_table", 1'b1, 1'b0, 1'b0);

    // Bounce shorter than the window must be ignored entirely.
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      bus.btn_up = (i % 2 == 0);
      tick(2);
    end
    bus.btn_up = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick(1);
      if (bus.changed === 1'b1) pulses++;
    end
    check("bounce_num", bus.number, last_num);
    check("bounce_pulses", pulses, 0);
    ev("clean_after_bounce", 1'b1, 1'b0, 1'b0);

    ev("clear_to_0", 1'b0, 1'b0, 1'b1);
    ev("down_at_0", 1'b0, 1'b1, 1'b0);
    ev("clear_again", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) ev("climb50", 1'b1, 1'b0, 1'b0);
    ev("simul_up_dn_50", 1'b1, 1'b1, 1'b0);
    ev("simul_all_50", 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 99; i++) ev("climb99", 1'b1, 1'b0, 1'b0);
    ev("sat_up1", 1'b1, 1'b0, 1'b0);
    ev("sat_up2", 1'b1, 1'b0, 1'b0);
    ev("sat_up3", 1'b1, 1'b0, 1'b0);

    ev("clear_for_7", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) ev("climb7", 1'b1, 1'b0, 1'b0);

    // Reset while the down press is two cycles into its debounce window.
    bus.btn_down = 1'b1;
    tick(4);
    reset = 1'b0;
    #1;
    check("middeb_rst_num", bus.number, 0);
    check("middeb_rst_min", bus.at_min, 1);
    check("middeb_rst_chg", bus.changed, 0);
    tick(2);
    reset    = 1'b1;
    model    = 0;
    last_num = 0;
    e = predict(1'b0, 1'b1, 1'b0);
    apply("held_after_rst", 1'b0, 1'b1, 1'b0, 20, e);

    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
